// File: rtl/afc_ncntr.sv
// Digital frequency counter for the AFC loop: counts rising edges of the divided
// VCO while the controller holds the count window open, and hands back the result on request.
module afc_ncntr #(
  parameter int CNT_W       = 14,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             afc_cntr_rstn,
  input  logic             afc_cntr_en,
  input  logic             afc_cntr_datasyn,
  input  logic             vco_div_in,
  output logic [CNT_W-1:0] a2d_afc_ncntr,
  output logic             ncntr_valid,
  output logic             ncntr_ovf,
  output logic             afc_cntr_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sync_d_reg;
  logic                   vco_edge;

  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [CNT_W-1:0]       ncntr_reg, ncntr_next;
  logic                   valid_reg, valid_next;
  logic                   ovf_reg, ovf_next;
  logic                   busy_reg, busy_next;
  logic                   cnt_inc;

  // Synchronizer chain; cleared only by rstn so a level that is already high
  // when the controller clears the counter can never look like a new edge.
  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or negedge rstn) begin
          if (!rstn) sync_reg[gi] <= 1'b0;
          else       sync_reg[gi] <= vco_div_in;
        end
      end else begin : g_rest
        always_ff @(posedge clk or negedge rstn) begin
          if (!rstn) sync_reg[gi] <= 1'b0;
          else       sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sync_d_reg <= 1'b0;
    else       sync_d_reg <= sync_reg[SYNC_STAGES-1];
  end

  assign vco_edge = sync_reg[SYNC_STAGES-1] & ~sync_d_reg;

  always_comb begin
    state_next = state_reg;
    if (!afc_cntr_rstn) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (afc_cntr_en)  state_next = COUNT;
        COUNT:   if (!afc_cntr_en) state_next = HOLD;
        HOLD:    if (afc_cntr_en)  state_next = COUNT;
        default: state_next = IDLE;
      endcase
    end
  end

  // Only edges seen while already in COUNT with the window still open are counted.
  assign cnt_inc = (state_reg == COUNT) && afc_cntr_en && vco_edge;

  always_comb begin
    cnt_next   = cnt_reg;
    ovf_next   = ovf_reg;
    ncntr_next = ncntr_reg;
    valid_next = 1'b0;
    busy_next  = (state_next == COUNT);
    if (!afc_cntr_rstn) begin
      cnt_next   = '0;
      ovf_next   = 1'b0;
      ncntr_next = '0;
    end else begin
      // Capture sees the pre-increment value; a coincident edge lands in cnt_reg only.
      if (afc_cntr_datasyn) begin
        ncntr_next = cnt_reg;
        valid_next = 1'b1;
      end
      if (cnt_inc) begin
        if (cnt_reg == CNT_MAX) ovf_next = 1'b1;
        else                    cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      ncntr_reg <= '0;
      valid_reg <= 1'b0;
      ovf_reg   <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ncntr_reg <= ncntr_next;
      valid_reg <= valid_next;
      ovf_reg   <= ovf_next;
      busy_reg  <= busy_next;
    end
  end

  assign a2d_afc_ncntr = ncntr_reg;
  assign ncntr_valid   = valid_reg;
  assign ncntr_ovf     = ovf_reg;
  assign afc_cntr_busy = busy_reg;

endmodule
